// File: rtl/mem_packet_writer_if.sv
// Handshake and memory-port bundle between an upstream word source and mem_packet_writer.
interface mem_packet_writer_if #(
  parameter int WORD_WIDTH = 16
);
  logic                  start;
  logic [WORD_WIDTH-1:0] base_addr;
  logic                  in_valid;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] address;
  logic                  wr_en;
  logic [WORD_WIDTH-1:0] data_out;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (
    output start, base_addr, in_valid, in_data, in_last,
    input  in_ready, address, wr_en, data_out, busy, done, overflow
  );

  modport slave (
    input  start, base_addr, in_valid, in_data, in_last,
    output in_ready, address, wr_en, data_out, busy, done, overflow
  );
endinterface

// File: rtl/mem_packet_writer.sv
// Streams 16-bit words big-endian into byte-addressed memory from base+2, then writes
// a {overflow, count} header word at base.
module mem_packet_writer #(
  parameter int MEM_DEPTH  = 1024,
  parameter int WORD_WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  mem_packet_writer_if.slave bus
);
  localparam logic [WORD_WIDTH-1:0] LAST_SLOT  = WORD_WIDTH'(MEM_DEPTH - 2);
  localparam logic [WORD_WIDTH-1:0] WORD_BYTES = WORD_WIDTH'(2);

  typedef enum logic [1:0] {IDLE, STREAM, HEADER, DONE} state_t;

  state_t                state, state_nxt;
  logic [WORD_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
  logic [WORD_WIDTH-1:0] base, base_nxt;
  logic [WORD_WIDTH-1:0] count, count_nxt;
  logic [WORD_WIDTH-1:0] address, address_nxt;
  logic [WORD_WIDTH-1:0] data_out, data_out_nxt;
  logic                  wr_en, wr_en_nxt;
  logic                  done, done_nxt;
  logic                  overflow, overflow_nxt;

  logic [WORD_WIDTH-1:0] base_aligned;
  logic [WORD_WIDTH-1:0] start_ptr;
  logic [WORD_WIDTH-1:0] ptr_inc;
  logic                  space;
  logic                  in_ready;
  logic                  accept;

  function automatic logic [WORD_WIDTH-1:0] header_word(input logic                  ovf,
                                                        input logic [WORD_WIDTH-2:0] cnt);
    return {ovf, cnt};
  endfunction

  assign base_aligned = bus.base_addr & ~WORD_WIDTH'(1);
  assign start_ptr    = base_aligned + WORD_BYTES;
  assign ptr_inc      = wr_ptr + WORD_BYTES;
  assign space        = (wr_ptr <= LAST_SLOT);
  assign in_ready     = (state == STREAM) && space;
  assign accept       = bus.in_valid && in_ready;

  always_comb begin
    state_nxt    = state;
    wr_ptr_nxt   = wr_ptr;
    base_nxt     = base;
    count_nxt    = count;
    address_nxt  = address;
    data_out_nxt = data_out;
    overflow_nxt = overflow;
    wr_en_nxt    = 1'b0;
    done_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          base_nxt     = base_aligned;
          wr_ptr_nxt   = start_ptr;
          count_nxt    = '0;
          overflow_nxt = 1'b0;
          // A base too close to the top leaves no payload slot at all.
          if (start_ptr > LAST_SLOT) begin
            overflow_nxt = 1'b1;
            state_nxt    = HEADER;
          end else begin
            state_nxt    = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          address_nxt  = wr_ptr;
          data_out_nxt = bus.in_data;
          wr_en_nxt    = 1'b1;
          wr_ptr_nxt   = ptr_inc;
          count_nxt    = count + 1'b1;
          if (bus.in_last) begin
            state_nxt    = HEADER;
          end else if (ptr_inc > LAST_SLOT) begin
            overflow_nxt = 1'b1;
            state_nxt    = HEADER;
          end
        end
      end
      HEADER: begin
        address_nxt  = base;
        data_out_nxt = header_word(overflow, count[WORD_WIDTH-2:0]);
        wr_en_nxt    = 1'b1;
        state_nxt    = DONE;
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      base     <= '0;
      count    <= '0;
      address  <= '0;
      data_out <= '0;
      wr_en    <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      base     <= base_nxt;
      count    <= count_nxt;
      address  <= address_nxt;
      data_out <= data_out_nxt;
      wr_en    <= wr_en_nxt;
      done     <= done_nxt;
      overflow <= overflow_nxt;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.address  = address;
  assign bus.wr_en    = wr_en;
  assign bus.data_out = data_out;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_mem_packet_writer.sv
// Randomized bench for mem_packet_writer: a byte memory behind the port and a packet-level
// reference model that lays out payload and header from the packet rules.
module tb_mem_packet_writer;
  localparam int MEM_DEPTH = 1024;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_packet_writer_if #(.WORD_WIDTH(16)) bus ();

  mem_packet_writer #(.MEM_DEPTH(MEM_DEPTH), .WORD_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [7:0]  mem     [MEM_DEPTH];
  logic [7:0]  exp_mem [MEM_DEPTH];
  logic [15:0] words   [16];
  logic        lasts   [16];
  int          gaps    [16];

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int wr_cnt, done_cnt, done_cyc, hdr_cyc;
  logic [15:0] hdr_addr, hdr_data;

  // Memory behind the port: high byte at the lower address.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.wr_en === 1'b1 && bus.address < 16'(MEM_DEPTH - 1)) begin
      mem[bus.address[9:0]]         <= bus.data_out[15:8];
      mem[bus.address[9:0] + 10'd1] <= bus.data_out[7:0];
    end
  end

  // The last write of a packet is its header, so the latest write is kept.
  always @(negedge clock) begin
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      hdr_addr = bus.address;
      hdr_data = bus.data_out;
      hdr_cyc  = cyc;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < MEM_DEPTH; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  task automatic model_packet(input logic [15:0] b, input int n, input bit hdr,
                              output int acc, output logic ovf, output logic [15:0] hword);
    logic [15:0] bb, p;
    bb  = b & 16'hFFFE;
    p   = bb + 16'd2;
    acc = 0;
    ovf = 1'b0;
    if (p > 16'd1022) ovf = 1'b1;
    else begin
      for (int i = 0; i < n; i++) begin
        exp_mem[p[9:0]]         = words[i][15:8];
        exp_mem[p[9:0] + 10'd1] = words[i][7:0];
        p = p + 16'd2;
        acc++;
        if (lasts[i]) break;
        if (p > 16'd1022) begin ovf = 1'b1; break; end
      end
    end
    hword = {ovf, 15'(acc)};
    if (hdr) begin
      exp_mem[bb[9:0]]         = hword[15:8];
      exp_mem[bb[9:0] + 10'd1] = hword[7:0];
    end
  endtask

  task automatic run_packet(input logic [15:0] b, input int n, input logic [15:0] restart,
                            output int acc, output int last_cyc);
    int waited;
    wr_cnt = 0; done_cnt = 0; acc = 0; last_cyc = -1;
    @(negedge clock); bus.start = 1'b1; bus.base_addr = b;
    @(negedge clock); bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 1 && restart != 16'd0) begin
        bus.start = 1'b1; bus.base_addr = restart;
        @(negedge clock); bus.start = 1'b0;
      end
      repeat (gaps[i]) @(negedge clock);
      bus.in_valid = 1'b1; bus.in_data = words[i]; bus.in_last = lasts[i];
      waited = 0;
      while (!bus.in_ready && waited < 6) begin @(negedge clock); waited++; end
      if (!bus.in_ready) begin bus.in_valid = 1'b0; break; end
      @(negedge clock);
      bus.in_valid = 1'b0;
      acc++;
      last_cyc = cyc;
      if (lasts[i]) break;
    end
    bus.in_valid = 1'b0;
    waited = 0;
    while (done_cnt == 0 && waited < 20) begin @(negedge clock); waited++; end
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    vectors++; if (bus.address !== 16'h0)  begin errors++; $display("FAIL reset_address got %h want 0000", bus.address); end
    vectors++; if (bus.wr_en !== 1'b0)     begin errors++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
    vectors++; if (bus.data_out !== 16'h0) begin errors++; $display("FAIL reset_data_out got %h want 0000", bus.data_out); end
    vectors++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    vectors++; if (bus.overflow !== 1'b0)  begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    vectors++; if (bus.in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    vectors++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    reset = 1'b0;
  endtask

  task automatic test_basic(input int gap, input string tag);
    int acc, lc, macc, nbad; logic movf; logic [15:0] hw;
    logic [7:0] expect_bytes [8];
    expect_bytes = '{8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    words[0] = 16'hA1B2; words[1] = 16'hC3D4; words[2] = 16'hE5F6;
    lasts[0] = 1'b0; lasts[1] = 1'b0; lasts[2] = 1'b1;
    for (int i = 0; i < 3; i++) gaps[i] = (i == 0) ? 0 : gap;
    model_packet(16'h0010, 3, 1'b1, macc, movf, hw);
    run_packet(16'h0010, 3, 16'h0, acc, lc);
    nbad = 0;
    for (int i = 0; i < 8; i++) if (mem[16 + i] !== expect_bytes[i]) nbad++;
    vectors++; if (nbad != 0) begin errors++; $display("FAIL %s_bytes got %0d bad bytes want 0 (mem[10]=%h mem[12]=%h)", tag, nbad, mem[16], mem[18]); end
    vectors++; if (acc != macc) begin errors++; $display("FAIL %s_accepts got %0d want %0d", tag, acc, macc); end
    vectors++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL %s_overflow got %b want 0", tag, bus.overflow); end
    vectors++; if (done_cnt != 1) begin errors++; $display("FAIL %s_done_count got %0d want 1", tag, done_cnt); end
    // Header register loads one edge after the last accept, done one edge later.
    vectors++; if (done_cyc != lc + 2 || hdr_cyc != lc + 1) begin errors++; $display("FAIL %s_latency got hdr %0d done %0d want %0d %0d", tag, hdr_cyc, done_cyc, lc + 1, lc + 2); end
    vectors++; if (wr_cnt != 4) begin errors++; $display("FAIL %s_wr_en_cycles got %0d want 4", tag, wr_cnt); end
    nbad = mem_diff();
    vectors++; if (nbad != 0) begin errors++; $display("FAIL %s_mem got %0d bad bytes want 0", tag, nbad); end
    vectors++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after got %b want 0", tag, bus.busy); end
    for (int i = 0; i < MEM_DEPTH; i++) exp_mem[i] = mem[i];
  endtask

  task automatic test_overflow();
    int acc, lc, macc, nbad; logic movf; logic [15:0] hw;
    for (int i = 0; i < 5; i++) begin words[i] = 16'($urandom); lasts[i] = 1'b0; gaps[i] = 0; end
    model_packet(16'h03F8, 5, 1'b1, macc, movf, hw);
    run_packet(16'h03F8, 5, 16'h0, acc, lc);
    vectors++; if (acc != 3 || acc != macc) begin errors++; $display("FAIL ovf_accepts got %0d want 3", acc); end
    vectors++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    vectors++; if (hdr_addr !== 16'h03F8 || hdr_data !== 16'h8003 || hw !== 16'h8003) begin errors++; $display("FAIL ovf_header got %h@%h want 8003@03f8", hdr_data, hdr_addr); end
    vectors++; if (done_cnt != 1) begin errors++; $display("FAIL ovf_done_count got %0d want 1", done_cnt); end
    nbad = mem_diff();
    vectors++; if (nbad != 0) begin errors++; $display("FAIL ovf_mem got %0d bad bytes want 0", nbad); end
    for (int i = 0; i < MEM_DEPTH; i++) exp_mem[i] = mem[i];

    // No room for even one payload word.
    words[0] = 16'h1234; lasts[0] = 1'b1; gaps[0] = 0;
    model_packet(16'h03FE, 1, 1'b1, macc, movf, hw);
    run_packet(16'h03FE, 1, 16'h0, acc, lc);
    vectors++; if (acc != 0) begin errors++; $display("FAIL nofit_accepts got %0d want 0", acc); end
    vectors++; if (hdr_addr !== 16'h03FE || hdr_data !== 16'h8000 || bus.overflow !== 1'b1) begin errors++; $display("FAIL nofit_header got %h@%h ovf %b want 8000@03fe ovf 1", hdr_data, hdr_addr, bus.overflow); end
    nbad = mem_diff();
    vectors++; if (nbad != 0 || done_cnt != 1) begin errors++; $display("FAIL nofit_mem got %0d bad bytes %0d dones want 0 1", nbad, done_cnt); end
    for (int i = 0; i < MEM_DEPTH; i++) exp_mem[i] = mem[i];

    // Exact fit with last on the final slot is not an overflow.
    for (int i = 0; i < 3; i++) begin words[i] = 16'($urandom); lasts[i] = (i == 2); gaps[i] = 0; end
    model_packet(16'h03F8, 3, 1'b1, macc, movf, hw);
    run_packet(16'h03F8, 3, 16'h0, acc, lc);
    vectors++; if (hdr_data !== 16'h0003 || bus.overflow !== 1'b0) begin errors++; $display("FAIL fit_header got %h ovf %b want 0003 ovf 0", hdr_data, bus.overflow); end
    nbad = mem_diff();
    vectors++; if (nbad != 0) begin errors++; $display("FAIL fit_mem got %0d bad bytes want 0", nbad); end
    for (int i = 0; i < MEM_DEPTH; i++) exp_mem[i] = mem[i];
  endtask

  task automatic test_odd_base_restart();
    int acc, lc, macc, nbad; logic movf; logic [15:0] hw;
    for (int i = 0; i < 3; i++) begin words[i] = 16'($urandom); lasts[i] = (i == 2); gaps[i] = 1; end
    model_packet(16'h0011, 3, 1'b1, macc, movf, hw);
    run_packet(16'h0011, 3, 16'h0100, acc, lc);
    vectors++; if (hdr_addr !== 16'h0010 || hdr_data !== 16'h0003) begin errors++; $display("FAIL oddbase_header got %h@%h want 0003@0010", hdr_data, hdr_addr); end
    nbad = mem_diff();
    vectors++; if (nbad != 0) begin errors++; $display("FAIL oddbase_mem got %0d bad bytes want 0", nbad); end
    vectors++; if (done_cnt != 1) begin errors++; $display("FAIL oddbase_done_count got %0d want 1", done_cnt); end
    for (int i = 0; i < MEM_DEPTH; i++) exp_mem[i] = mem[i];
  endtask

  task automatic test_reset_abort();
    int macc, nbad, waited; logic movf; logic [15:0] hw;
    logic [7:0] pre0, pre1;
    pre0 = mem[16'h40]; pre1 = mem[16'h41];
    for (int i = 0; i < 4; i++) begin words[i] = 16'($urandom); lasts[i] = (i == 3); end
    model_packet(16'h0040, 2, 1'b0, macc, movf, hw);
    wr_cnt = 0; done_cnt = 0;
    @(negedge clock); bus.start = 1'b1; bus.base_addr = 16'h0040;
    @(negedge clock); bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_data = words[i]; bus.in_last = 1'b0;
      waited = 0;
      while (!bus.in_ready && waited < 6) begin @(negedge clock); waited++; end
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    vectors++; if (bus.wr_en !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_idle got wr_en %b busy %b want 0 0", bus.wr_en, bus.busy); end
    repeat (10) @(negedge clock);
    vectors++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", done_cnt); end
    vectors++; if (mem[16'h40] !== pre0 || mem[16'h41] !== pre1) begin errors++; $display("FAIL abort_header got %h%h want %h%h", mem[16'h40], mem[16'h41], pre0, pre1); end
    nbad = mem_diff();
    vectors++; if (nbad != 0) begin errors++; $display("FAIL abort_mem got %0d bad bytes want 0", nbad); end
    for (int i = 0; i < MEM_DEPTH; i++) exp_mem[i] = mem[i];
  endtask

  task automatic test_random();
    int acc, lc, macc, nbad, n; logic movf; logic [15:0] hw, b;
    for (int p = 0; p < 12; p++) begin
      b = (p % 2 == 0) ? 16'($urandom_range(0, 16'h03FF)) : 16'($urandom_range(16'h03E8, 16'h03FF));
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        words[i] = 16'($urandom); lasts[i] = (i == n - 1); gaps[i] = $urandom_range(0, 2);
      end
      model_packet(b, n, 1'b1, macc, movf, hw);
      run_packet(b, n, 16'h0, acc, lc);
      vectors++; if (acc != macc) begin errors++; $display("FAIL rand%0d_accepts base %h got %0d want %0d", p, b, acc, macc); end
      vectors++; if (bus.overflow !== movf) begin errors++; $display("FAIL rand%0d_overflow got %b want %b", p, bus.overflow, movf); end
      vectors++; if (hdr_addr !== (b & 16'hFFFE) || hdr_data !== hw) begin errors++; $display("FAIL rand%0d_header got %h@%h want %h@%h", p, hdr_data, hdr_addr, hw, b & 16'hFFFE); end
      vectors++; if (done_cnt != 1) begin errors++; $display("FAIL rand%0d_done_count got %0d want 1", p, done_cnt); end
      if (acc > 0) begin
        vectors++; if (done_cyc != lc + 2) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", p, done_cyc, lc + 2); end
      end
      nbad = mem_diff();
      vectors++; if (nbad != 0) begin errors++; $display("FAIL rand%0d_mem got %0d bad bytes want 0", p, nbad); end
      for (int i = 0; i < MEM_DEPTH; i++) exp_mem[i] = mem[i];
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.base_addr = 16'h0; bus.in_valid = 1'b0;
    bus.in_data = 16'h0; bus.in_last = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      mem[i] = 8'($urandom);
      exp_mem[i] = mem[i];
    end
    test_reset();
    test_basic(0, "b2b");
    test_basic(2, "gaps");
    test_overflow();
    test_odd_base_restart();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
